// File: rtl/cic_interpolator_if.sv
// ---------------------------------------------------------------------------
// cic_interpolator_if
// Sample-stream bundle for the CIC interpolator.
//   x_in    : low-rate input sample, signed two's complement
//   x_valid : x_in holds a sample
//   x_ready : the filter takes a sample this cycle
//   y_out   : full-rate output sample, signed two's complement
//   y_valid : y_out holds a filter output
// master = sample source / output sink, slave = the filter.
// ---------------------------------------------------------------------------
interface cic_interpolator_if #(
    parameter int WIDTH = 8
);
    logic signed [WIDTH-1:0] x_in;
    logic                    x_valid;
    logic                    x_ready;
    logic signed [WIDTH-1:0] y_out;
    logic                    y_valid;

    modport master (
        output x_in, x_valid,
        input  x_ready, y_out, y_valid
    );

    modport slave (
        input  x_in, x_valid,
        output x_ready, y_out, y_valid
    );
endinterface

// File: rtl/cic_interpolator.sv
// ---------------------------------------------------------------------------
// cic_interpolator
// CIC interpolation filter: STAGES comb stages at the low rate, zero-stuffing
// by RATE, then STAGES integrator stages at the clock rate. The output is
// scaled down by RATE^(STAGES-1) so the DC gain is exactly one.
//
// Ports
//   clock    : sole clock, rising edge
//   reset    : synchronous, active-high, clears all state
//   bus      : cic_interpolator_if.slave (x_in/x_valid/x_ready in,
//              y_out/y_valid out)
//   underrun : sticky flag, set when an accept slot finds no sample
//              (only present when CIC_INT_UNDERRUN_EN is defined)
//
// Build option
//   CIC_INT_UNDERRUN_EN : adds the underrun port and its register. The data
//                         path is the same either way: a missing sample is
//                         fed into the combs as zero.
// ---------------------------------------------------------------------------
module cic_interpolator #(
    parameter int WIDTH  = 8,
    parameter int RATE   = 16,
    parameter int STAGES = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    cic_interpolator_if.slave        bus
`ifdef CIC_INT_UNDERRUN_EN
    ,
    output logic                     underrun
`endif
);
    localparam int LOG2R = $clog2(RATE);
    localparam int IW    = WIDTH + STAGES * LOG2R;
    localparam int SHIFT = (STAGES - 1) * LOG2R;
    localparam logic [LOG2R-1:0] PH_ONE = LOG2R'(1);

    logic [LOG2R-1:0]        ph_reg;
    logic                    accept;
    logic signed [IW-1:0]    x_ext;
    logic signed [IW-1:0]    comb_c [0:STAGES];
    logic signed [IW-1:0]    comb_d_reg [1:STAGES];
    logic signed [IW-1:0]    comb_reg;
    logic signed [IW-1:0]    integ_u;
    logic signed [IW-1:0]    integ_reg [1:STAGES];
    logic signed [WIDTH-1:0] y_out_reg;
    // Shift register of ones that walks from the first accept edge to the
    // edge where the first filtered value lands in y_out.
    logic [STAGES+1:0]       prime_reg;

    // RATE is a power of two, so the phase counter wraps on its own.
    always_ff @(posedge clock) begin
        if (reset) begin
            ph_reg <= '0;
        end else begin
            ph_reg <= ph_reg + PH_ONE;
        end
    end

    assign accept      = (ph_reg == '0);
    assign bus.x_ready = accept && !reset;

    // A missing sample on an accept slot enters the combs as zero.
    assign x_ext     = bus.x_valid ? IW'(bus.x_in) : '0;
    assign comb_c[0] = x_ext;

    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_comb
            assign comb_c[gi] = comb_c[gi-1] - comb_d_reg[gi];

            always_ff @(posedge clock) begin
                if (reset) begin
                    comb_d_reg[gi] <= '0;
                end else if (accept) begin
                    comb_d_reg[gi] <= comb_c[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            comb_reg <= '0;
        end else if (accept) begin
            comb_reg <= comb_c[STAGES];
        end
    end

    // Zero-stuffing: the comb result is presented to the integrators for
    // exactly one clock, the cycle after it was captured.
    assign integ_u = (ph_reg == PH_ONE) ? comb_reg : '0;

    // Integrators wrap modulo 2^IW; the comb section cancels the wrap exactly.
    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_integ
            if (gi == 1) begin : g_first
                always_ff @(posedge clock) begin
                    if (reset) begin
                        integ_reg[gi] <= '0;
                    end else begin
                        integ_reg[gi] <= integ_reg[gi] + integ_u;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clock) begin
                    if (reset) begin
                        integ_reg[gi] <= '0;
                    end else begin
                        integ_reg[gi] <= integ_reg[gi] + integ_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Dividing by RATE^(STAGES-1) is an arithmetic right shift, then keep
    // the low WIDTH bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            y_out_reg <= '0;
            prime_reg <= '0;
        end else begin
            y_out_reg <= WIDTH'(integ_reg[STAGES] >>> SHIFT);
            prime_reg <= {prime_reg[STAGES:0], 1'b1};
        end
    end

    assign bus.y_out   = y_out_reg;
    assign bus.y_valid = prime_reg[STAGES+1];

`ifdef CIC_INT_UNDERRUN_EN
    logic underrun_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            underrun_reg <= 1'b0;
        end else if (accept && !bus.x_valid) begin
            underrun_reg <= 1'b1;
        end
    end

    assign underrun = underrun_reg;
`endif
endmodule

// File: tb/tb_cic_interpolator.sv
// ---------------------------------------------------------------------------
// tb_cic_interpolator
// Scoreboard bench. Each accepted (or zero-fed) input sample pushes RATE
// expected output entries; the monitors pop one entry per valid output.
// Entries are either "don't care" (filter transient) or an exact value.
// A second instance (RATE=4, STAGES=1) checks the zero-order-hold response.
// ---------------------------------------------------------------------------
module tb_cic_interpolator;
    localparam int RATE = 16;

    typedef struct {
        bit care;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_z = 1'b1;
    always #5 clk = ~clk;

    cic_interpolator_if #(.WIDTH(8)) bus ();
    cic_interpolator_if #(.WIDTH(8)) zbus ();

`ifdef CIC_INT_UNDERRUN_EN
    logic underrun;
    logic underrun_z;
`endif

    cic_interpolator #(.WIDTH(8), .RATE(16), .STAGES(3)) dut (
        .clock    (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef CIC_INT_UNDERRUN_EN
        ,
        .underrun (underrun)
`endif
    );

    cic_interpolator #(.WIDTH(8), .RATE(4), .STAGES(1)) dut_z (
        .clock    (clk),
        .reset    (reset_z),
        .bus      (zbus)
`ifdef CIC_INT_UNDERRUN_EN
        ,
        .underrun (underrun_z)
`endif
    );

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    exp_t zq[$];
    bit   zdone = 1'b0;

    bit hs_en = 1'b0;
    int hs_cnt = 0;
    int hs_cyc = 0;

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Main scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.y_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.care) begin
                check("y_out", int'(bus.y_out), e.val);
            end
        end
    end

    // Zero-order-hold monitor: every entry is exact.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_z && zbus.y_valid && zq.size() > 0) begin
            e = zq.pop_front();
            check("zoh_y_out", int'(zbus.y_out), e.val);
        end
    end

    // Handshake pacing counter.
    always @(negedge clk) begin
        if (hs_en) begin
            hs_cyc++;
            if (bus.x_ready) hs_cnt++;
        end
    end

    // Present one sample (or a missing one) and wait for its accept slot.
    // mode: 0 = whole block don't care, 1 = first output exact, 2 = all exact.
    task automatic send(input int x, input bit v, input int mode, input int val);
        int guard;
        exp_t e;
        guard = 0;
        bus.x_in    = 8'(x);
        bus.x_valid = v;
        @(negedge clk);
        while (!bus.x_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.x_ready) begin
            check("accept_timeout", guard, 0);
        end
        for (int j = 0; j < RATE; j++) begin
            e.care = (mode == 2) || (mode == 1 && j == 0);
            e.val  = val;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_z(input int x);
        int guard;
        exp_t e;
        guard = 0;
        zbus.x_in    = 8'(x);
        zbus.x_valid = 1'b1;
        @(negedge clk);
        while (!zbus.x_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!zbus.x_ready) begin
            check("zoh_accept_timeout", guard, 0);
        end
        for (int j = 0; j < 4; j++) begin
            e.care = 1'b1;
            e.val  = x;
            zq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Zero-order hold: 10 then zeros gives four 10s then zeros.
    initial begin
        reset_z      = 1'b1;
        zbus.x_in    = 8'sd0;
        zbus.x_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("zoh_rst_y_valid", int'(zbus.y_valid), 0);
        end
        reset_z = 1'b0;
        send_z(10);
        for (int k = 0; k < 3; k++) send_z(0);
        repeat (12) @(posedge clk);
        #1;
        check("zoh_queue_drained", zq.size(), 0);
        zdone = 1'b1;
    end

    initial begin
        bus.x_in    = 8'sd55;
        bus.x_valid = 1'b1;
        reset       = 1'b1;

        // Reset held with x_valid high.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_x_ready", int'(bus.x_ready), 0);
            check("rst_y_out", int'(bus.y_out), 0);
            check("rst_y_valid", int'(bus.y_valid), 0);
`ifdef CIC_INT_UNDERRUN_EN
            check("rst_underrun", int'(underrun), 0);
`endif
        end
        reset = 1'b0;
        #1;
        check("first_x_ready", int'(bus.x_ready), 1);

        // DC 100; handshake pacing measured over ten accept periods.
        send(100, 1'b1, 0, 0);
        send(100, 1'b1, 0, 0);
        hs_en = 1'b1;
        for (int k = 0; k < 10; k++) send(100, 1'b1, 2, 100);
        hs_en = 1'b0;
        check("hs_ready_pulses", hs_cnt, 10);
        check("hs_cycles", hs_cyc, 160);

        // DC -128.
        send(-128, 1'b1, 0, 0);
        send(-128, 1'b1, 0, 0);
        for (int k = 0; k < 4; k++) send(-128, 1'b1, 2, -128);

        // DC 50 with one missing sample. First output of the dip block:
        // 50*(h[16]+h[32]) >>> 8 = 50*(150+105) >>> 8 = 49.
        send(50, 1'b1, 0, 0);
        send(50, 1'b1, 0, 0);
        send(50, 1'b1, 2, 50);
        send(50, 1'b1, 2, 50);
`ifdef CIC_INT_UNDERRUN_EN
        check("underrun_before", int'(underrun), 0);
`endif
        send(50, 1'b0, 1, 49);
`ifdef CIC_INT_UNDERRUN_EN
        check("underrun_set", int'(underrun), 1);
`endif
        send(50, 1'b1, 0, 0);
        send(50, 1'b1, 0, 0);
        for (int k = 0; k < 3; k++) send(50, 1'b1, 2, 50);
`ifdef CIC_INT_UNDERRUN_EN
        check("underrun_sticky", int'(underrun), 1);
`endif

        // DC 100 then a one-cycle reset mid-stream.
        send(100, 1'b1, 0, 0);
        send(100, 1'b1, 0, 0);
        send(100, 1'b1, 2, 100);
        send(100, 1'b1, 2, 100);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_x_ready", int'(bus.x_ready), 0);
        @(posedge clk);
        #1;
        sbq.delete();
        check("mid_rst_y_out", int'(bus.y_out), 0);
        check("mid_rst_y_valid", int'(bus.y_valid), 0);
`ifdef CIC_INT_UNDERRUN_EN
        check("mid_rst_underrun", int'(underrun), 0);
`endif
        reset = 1'b0;
        #1;
        check("restart_x_ready", int'(bus.x_ready), 1);
        send(100, 1'b1, 0, 0);
        send(100, 1'b1, 0, 0);
        for (int k = 0; k < 3; k++) send(100, 1'b1, 2, 100);

        repeat (30) @(posedge clk);
        #1;
        check("queue_drained", sbq.size(), 0);

        while (!zdone) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
